// File: rtl/uart_pkg.sv
// Shared types and constants for the parallel-strobe UART responder.
// Serial frame shape and the reset levels of every status output live here.
package uart_pkg;

    localparam int   FRAME_DATA_BITS = 8;
    localparam logic IDLE_LEVEL      = 1'b1;

    localparam logic       TBRE_RST      = 1'b1;
    localparam logic       TSRE_RST      = 1'b1;
    localparam logic       DATAREADY_RST = 1'b0;
    localparam logic [7:0] DATA_O_RST    = 8'h00;

    // BREAK is RX-only: after a bad frame, wait for the line to return high.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_t;

    function automatic logic even_parity(input logic [FRAME_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/cpld_uart_responder_if.sv
// Parallel UART strobe bus between the memory/IO controller (master) and the responder (slave).
interface cpld_uart_responder_if;
    import uart_pkg::*;

    logic                       uart_rdn;
    logic                       uart_wrn;
    logic [FRAME_DATA_BITS-1:0] uart_data_i;
    logic [FRAME_DATA_BITS-1:0] uart_data_o;
    logic                       uart_data_oe;
    logic                       uart_dataready;
    logic                       uart_tbre;
    logic                       uart_tsre;

    modport master (
        output uart_rdn, uart_wrn, uart_data_i,
        input  uart_data_o, uart_data_oe, uart_dataready, uart_tbre, uart_tsre
    );

    modport slave (
        input  uart_rdn, uart_wrn, uart_data_i,
        output uart_data_o, uart_data_oe, uart_dataready, uart_tbre, uart_tsre
    );

endinterface

// File: rtl/uart_rx_deser.sv
// rxd synchronizer plus mid-bit sampling deserializer; emits a byte with a 1-cycle valid.
// UART_EVEN_PARITY_EN adds a parity bit check between DATA and STOP.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rxd,
    output logic [FRAME_DATA_BITS-1:0] rx_data,
    output logic                       rx_valid
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(FRAME_DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_DATA_BITS - 1);

    logic [SYNC_STAGES-1:0]     sync_reg;
    logic                       rxd_s;
    uart_state_t                state_reg, state_next;
    logic [BAUD_W-1:0]          baud_reg, baud_next;
    logic [BIT_W-1:0]           bit_reg, bit_next;
    logic [FRAME_DATA_BITS-1:0] shift_reg, shift_next;
    logic                       baud_end;

    assign rxd_s    = sync_reg[SYNC_STAGES-1];
    assign baud_end = (baud_reg == BAUD_LAST);
    assign rx_data  = shift_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg  <= {SYNC_STAGES{IDLE_LEVEL}};
            state_reg <= ST_IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], rxd};
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg + BAUD_W'(1);
        bit_next   = bit_reg;
        shift_next = shift_reg;
        rx_valid   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // The detection cycle counts as tick 0 of the start bit.
                baud_next = '0;
                if (!rxd_s) begin
                    state_next = ST_START;
                    baud_next  = BAUD_W'(1);
                end
            end
            ST_START: begin
                if (baud_reg == BAUD_HALF) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = rxd_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_next  = '0;
                    shift_next = {rxd_s, shift_reg[FRAME_DATA_BITS-1:1]};
                    if (bit_reg == BIT_LAST) begin
`ifdef UART_EVEN_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end else begin
                        bit_next = bit_reg + BIT_W'(1);
                    end
                end
            end
`ifdef UART_EVEN_PARITY_EN
            ST_PARITY: begin
                if (baud_end) begin
                    baud_next  = '0;
                    state_next = (rxd_s != even_parity(shift_reg)) ? ST_BREAK : ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (baud_end) begin
                    baud_next = '0;
                    if (rxd_s) begin
                        rx_valid   = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                baud_next = '0;
                if (rxd_s) state_next = ST_IDLE;
            end
            default: begin
                baud_next  = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/cpld_uart_responder.sv
// Device side of the parallel UART strobe bus: strobed writes become serial frames on txd,
// rxd bytes are held in rbr for strobed reads. UART_EVEN_PARITY_EN selects 8E1 instead of 8N1.
module cpld_uart_responder
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    cpld_uart_responder_if.slave        bus,
    output logic                        txd,
    input  logic                        rxd
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(FRAME_DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_DATA_BITS - 1);

    logic [SYNC_STAGES-1:0] rdn_sync_reg, wrn_sync_reg;
    logic                   rdn_prev_reg, wrn_prev_reg;
    logic                   rdn_s, wrn_s, rdn_rise, wrn_fall;

    logic [FRAME_DATA_BITS-1:0] rx_data;
    logic                       rx_valid;
    logic [FRAME_DATA_BITS-1:0] rbr_reg;
    logic                       dataready_reg;

    uart_state_t                tx_state_reg, tx_state_next;
    logic [BAUD_W-1:0]          tx_baud_reg, tx_baud_next;
    logic [BIT_W-1:0]           tx_bit_reg, tx_bit_next;
    logic [FRAME_DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
    logic [FRAME_DATA_BITS-1:0] thr_reg, thr_next;
    logic                       thr_full_reg, thr_full_next;
    logic                       tsre_reg, tsre_next;
    logic                       tx_baud_end, load_shifter;
`ifdef UART_EVEN_PARITY_EN
    logic                       parity_reg, parity_next;
`endif

    assign rdn_s    = rdn_sync_reg[SYNC_STAGES-1];
    assign wrn_s    = wrn_sync_reg[SYNC_STAGES-1];
    assign rdn_rise = !rdn_prev_reg && rdn_s;
    assign wrn_fall = wrn_prev_reg && !wrn_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdn_sync_reg <= '1;
            wrn_sync_reg <= '1;
            rdn_prev_reg <= 1'b1;
            wrn_prev_reg <= 1'b1;
        end else begin
            rdn_sync_reg <= {rdn_sync_reg[SYNC_STAGES-2:0], bus.uart_rdn};
            wrn_sync_reg <= {wrn_sync_reg[SYNC_STAGES-2:0], bus.uart_wrn};
            rdn_prev_reg <= rdn_s;
            wrn_prev_reg <= wrn_s;
        end
    end

    uart_rx_deser #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
    );

    // A fresh byte beats a coincident read-completion, so dataready stays set on overrun.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rbr_reg       <= DATA_O_RST;
            dataready_reg <= DATAREADY_RST;
        end else if (rx_valid) begin
            rbr_reg       <= rx_data;
            dataready_reg <= 1'b1;
        end else if (rdn_rise) begin
            dataready_reg <= 1'b0;
        end
    end

    assign bus.uart_data_oe   = !rdn_s;
    assign bus.uart_data_o    = rdn_s ? DATA_O_RST : rbr_reg;
    assign bus.uart_dataready = dataready_reg;
    assign bus.uart_tbre      = !thr_full_reg;
    assign bus.uart_tsre      = tsre_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_reg <= ST_IDLE;
            tx_baud_reg  <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            thr_reg      <= '0;
            thr_full_reg <= !TBRE_RST;
            tsre_reg     <= TSRE_RST;
`ifdef UART_EVEN_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            tx_state_reg <= tx_state_next;
            tx_baud_reg  <= tx_baud_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            thr_reg      <= thr_next;
            thr_full_reg <= thr_full_next;
            tsre_reg     <= tsre_next;
`ifdef UART_EVEN_PARITY_EN
            parity_reg   <= parity_next;
`endif
        end
    end

    assign tx_baud_end = (tx_baud_reg == BAUD_LAST);

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        thr_next      = thr_reg;
        thr_full_next = thr_full_reg;
        tsre_next     = tsre_reg;
        load_shifter  = 1'b0;
        tx_baud_next  = (tx_state_reg == ST_IDLE || tx_baud_end) ? '0 : tx_baud_reg + BAUD_W'(1);
`ifdef UART_EVEN_PARITY_EN
        parity_next   = parity_reg;
`endif
        // Writes are only taken into an empty thr; loads only fire with thr full, so the two never collide.
        if (wrn_fall && !thr_full_reg) begin
            thr_next      = bus.uart_data_i;
            thr_full_next = 1'b1;
        end
        case (tx_state_reg)
            ST_IDLE: begin
                if (thr_full_reg) load_shifter = 1'b1;
            end
            ST_START: begin
                if (tx_baud_end) begin
                    tx_state_next = ST_DATA;
                    tx_bit_next   = '0;
                end
            end
            ST_DATA: begin
                if (tx_baud_end) begin
                    tx_shift_next = tx_shift_reg >> 1;
                    if (tx_bit_reg == BIT_LAST) begin
`ifdef UART_EVEN_PARITY_EN
                        tx_state_next = ST_PARITY;
`else
                        tx_state_next = ST_STOP;
`endif
                    end else begin
                        tx_bit_next = tx_bit_reg + BIT_W'(1);
                    end
                end
            end
`ifdef UART_EVEN_PARITY_EN
            ST_PARITY: begin
                if (tx_baud_end) tx_state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (tx_baud_end) begin
                    if (thr_full_reg) begin
                        load_shifter = 1'b1;
                    end else begin
                        tx_state_next = ST_IDLE;
                        tsre_next     = 1'b1;
                    end
                end
            end
            default: tx_state_next = ST_IDLE;
        endcase
        if (load_shifter) begin
            tx_state_next = ST_START;
            tx_shift_next = thr_reg;
            thr_full_next = 1'b0;
            tsre_next     = 1'b0;
`ifdef UART_EVEN_PARITY_EN
            parity_next   = even_parity(thr_reg);
`endif
        end
    end

    always_comb begin
        txd = IDLE_LEVEL;
        case (tx_state_reg)
            ST_START: txd = 1'b0;
            ST_DATA:  txd = tx_shift_reg[0];
`ifdef UART_EVEN_PARITY_EN
            ST_PARITY: txd = parity_reg;
`endif
            default:  txd = IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_cpld_uart_responder.sv
// Self-checking bench for cpld_uart_responder in its default 8N1 build, CLKS_PER_BIT=4.
module tb_cpld_uart_responder;
    import uart_pkg::*;

    localparam int CPB = 4;
    localparam int SS  = 2;
    localparam int FRAME_CYCLES = 10 * CPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rxd   = 1'b1;
    logic txd;

    cpld_uart_responder_if bus();

    cpld_uart_responder #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .txd   (txd),
        .rxd   (rxd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        bit         form_ok;
        int         start_cyc;
    } frame_t;
    frame_t txq[$];

    // Receive-side reference: last good byte and whether it is still unread.
    logic [7:0] exp_rbr;
    bit         exp_ready;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decodes txd into frames: every bit must hold for CPB cycles, start=0, stop=1.
    initial begin : tx_monitor
        logic [FRAME_CYCLES-1:0] s;
        bit     aborted;
        frame_t f;
        int     st;
        forever begin
            tick();
            if (rst_n && txd === 1'b0) begin
                st      = cyc;
                s[0]    = txd;
                aborted = 0;
                for (int i = 1; i < FRAME_CYCLES; i++) begin
                    tick();
                    if (!rst_n) aborted = 1;
                    s[i] = txd;
                end
                if (!aborted) begin
                    f.form_ok = (s[0] === 1'b0) && (s[9*CPB] === 1'b1);
                    for (int b = 0; b < 10; b++)
                        for (int c = 1; c < CPB; c++)
                            if (s[b*CPB+c] !== s[b*CPB]) f.form_ok = 0;
                    for (int k = 0; k < 8; k++) f.data[k] = s[(k+1)*CPB];
                    f.start_cyc = st;
                    txq.push_back(f);
                end
            end
        end
    end

    task automatic drive_write(input logic [7:0] d);
        bus.uart_data_i = d;
        bus.uart_wrn    = 1'b0;
        repeat (SS + 2) tick();
        bus.uart_wrn    = 1'b1;
        repeat (2) tick();
    endtask

    task automatic wait_tsre_high(input int budget, output bit hit);
        hit = 0;
        for (int i = 0; i < budget; i++) begin
            if (bus.uart_tsre === 1'b1) begin
                hit = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            repeat (CPB) tick();
        end
        rxd = 1'b1;
        repeat (2 * CPB) tick();
        if (stop_bit) begin
            exp_rbr   = d;
            exp_ready = 1;
        end
    endtask

    task automatic do_read(output logic [7:0] d, output logic oe, output logic ready_after);
        bus.uart_rdn = 1'b0;
        repeat (SS + 1) tick();
        d  = bus.uart_data_o;
        oe = bus.uart_data_oe;
        bus.uart_rdn = 1'b1;
        repeat (SS + 3) tick();
        ready_after = bus.uart_dataready;
        exp_ready   = 0;
    endtask

    task automatic test_reset();
        bus.uart_rdn    = 1'b1;
        bus.uart_wrn    = 1'b1;
        bus.uart_data_i = 8'h00;
        rxd   = 1'b1;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        exp_rbr   = 8'h00;
        exp_ready = 0;
        n_checks++; if (txd !== 1'b1) $display("FAIL reset_txd: got %b expected 1", txd); else n_pass++;
        n_checks++; if (bus.uart_tbre !== 1'b1) $display("FAIL reset_tbre: got %b expected 1", bus.uart_tbre); else n_pass++;
        n_checks++; if (bus.uart_tsre !== 1'b1) $display("FAIL reset_tsre: got %b expected 1", bus.uart_tsre); else n_pass++;
        n_checks++; if (bus.uart_dataready !== 1'b0) $display("FAIL reset_dataready: got %b expected 0", bus.uart_dataready); else n_pass++;
        n_checks++; if (bus.uart_data_oe !== 1'b0) $display("FAIL reset_oe: got %b expected 0", bus.uart_data_oe); else n_pass++;
        n_checks++; if (bus.uart_data_o !== 8'h00) $display("FAIL reset_data_o: got %h expected 00", bus.uart_data_o); else n_pass++;
    endtask

    task automatic test_single_write();
        int     tbre_low = 0;
        int     tsre_low = 0;
        frame_t f;
        txq.delete();
        bus.uart_data_i = 8'hA5;
        bus.uart_wrn    = 1'b0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (i == SS + 1) bus.uart_wrn = 1'b1;
            if (bus.uart_tbre === 1'b0) tbre_low++;
            if (bus.uart_tsre === 1'b0) tsre_low++;
        end
        n_checks++; if (tbre_low != 1) $display("FAIL write_tbre_low_cycles: got %0d expected 1", tbre_low); else n_pass++;
        n_checks++; if (tsre_low != FRAME_CYCLES) $display("FAIL write_tsre_low_cycles: got %0d expected %0d", tsre_low, FRAME_CYCLES); else n_pass++;
        n_checks++; if (bus.uart_tbre !== 1'b1) $display("FAIL write_tbre_end: got %b expected 1", bus.uart_tbre); else n_pass++;
        n_checks++; if (txd !== 1'b1) $display("FAIL write_txd_idle: got %b expected 1", txd); else n_pass++;
        n_checks++; if (txq.size() != 1) $display("FAIL write_frame_count: got %0d expected 1", txq.size()); else n_pass++;
        if (txq.size() > 0) begin
            f = txq.pop_front();
            n_checks++; if (f.data !== 8'hA5) $display("FAIL write_frame_data: got %h expected a5", f.data); else n_pass++;
            n_checks++; if (!f.form_ok) $display("FAIL write_frame_shape: got %b expected 1", f.form_ok); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        bit     hit;
        frame_t f0, f1;
        txq.delete();
        drive_write(8'h55);
        n_checks++; if (bus.uart_tbre !== 1'b1) $display("FAIL b2b_tbre_after_load: got %b expected 1", bus.uart_tbre); else n_pass++;
        drive_write(8'h0F);
        n_checks++; if (bus.uart_tbre !== 1'b0) $display("FAIL b2b_tbre_thr_full: got %b expected 0", bus.uart_tbre); else n_pass++;
        drive_write(8'hEE);
        n_checks++; if (bus.uart_tbre !== 1'b0) $display("FAIL b2b_tbre_after_ignored: got %b expected 0", bus.uart_tbre); else n_pass++;
        wait_tsre_high(200, hit);
        n_checks++; if (!hit) $display("FAIL b2b_tsre_timeout: got 0 expected 1"); else n_pass++;
        repeat (4) tick();
        n_checks++; if (txq.size() != 2) $display("FAIL b2b_frame_count: got %0d expected 2", txq.size()); else n_pass++;
        if (txq.size() >= 2) begin
            f0 = txq.pop_front();
            f1 = txq.pop_front();
            n_checks++; if (f0.data !== 8'h55 || !f0.form_ok) $display("FAIL b2b_frame0: got %h/%b expected 55/1", f0.data, f0.form_ok); else n_pass++;
            n_checks++; if (f1.data !== 8'h0F || !f1.form_ok) $display("FAIL b2b_frame1: got %h/%b expected 0f/1", f1.data, f1.form_ok); else n_pass++;
            n_checks++; if (f1.start_cyc - f0.start_cyc != FRAME_CYCLES) $display("FAIL b2b_gap: got %0d expected %0d", f1.start_cyc - f0.start_cyc, FRAME_CYCLES); else n_pass++;
        end
        txq.delete();
    endtask

    task automatic test_random_tx();
        logic [7:0] d;
        bit         hit;
        frame_t     f;
        for (int n = 0; n < 4; n++) begin
            txq.delete();
            d = 8'($urandom);
            drive_write(d);
            wait_tsre_high(100, hit);
            n_checks++; if (!hit) $display("FAIL rtx_tsre_timeout: got 0 expected 1"); else n_pass++;
            repeat (2) tick();
            if (txq.size() == 0) begin
                n_checks++; $display("FAIL rtx_no_frame: got 0 frames expected 1");
            end else begin
                f = txq.pop_front();
                n_checks++; if (f.data !== d || !f.form_ok) $display("FAIL rtx_frame: got %h/%b expected %h/1", f.data, f.form_ok, d); else n_pass++;
            end
        end
    endtask

    task automatic test_receive();
        logic [7:0] d;
        logic       oe, rdy;
        send_rx(8'h3C, 1'b1);
        n_checks++; if (bus.uart_dataready !== exp_ready) $display("FAIL rx_ready: got %b expected %b", bus.uart_dataready, exp_ready); else n_pass++;
        do_read(d, oe, rdy);
        n_checks++; if (d !== exp_rbr) $display("FAIL rx_data: got %h expected %h", d, exp_rbr); else n_pass++;
        n_checks++; if (oe !== 1'b1) $display("FAIL rx_oe: got %b expected 1", oe); else n_pass++;
        n_checks++; if (rdy !== 1'b0) $display("FAIL rx_ready_cleared: got %b expected 0", rdy); else n_pass++;
        n_checks++; if (bus.uart_data_o !== 8'h00 || bus.uart_data_oe !== 1'b0) $display("FAIL rx_bus_release: got %h/%b expected 00/0", bus.uart_data_o, bus.uart_data_oe); else n_pass++;
    endtask

    task automatic test_errors();
        rxd = 1'b0;
        tick();
        rxd = 1'b1;
        repeat (20) tick();
        n_checks++; if (bus.uart_dataready !== exp_ready) $display("FAIL err_glitch: got %b expected %b", bus.uart_dataready, exp_ready); else n_pass++;
        send_rx(8'h81, 1'b0);
        n_checks++; if (bus.uart_dataready !== exp_ready) $display("FAIL err_framing: got %b expected %b", bus.uart_dataready, exp_ready); else n_pass++;
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        logic       oe, rdy;
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        n_checks++; if (bus.uart_dataready !== exp_ready) $display("FAIL ovr_ready: got %b expected %b", bus.uart_dataready, exp_ready); else n_pass++;
        do_read(d, oe, rdy);
        n_checks++; if (d !== exp_rbr) $display("FAIL ovr_data: got %h expected %h", d, exp_rbr); else n_pass++;
        n_checks++; if (rdy !== 1'b0) $display("FAIL ovr_ready_cleared: got %b expected 0", rdy); else n_pass++;
    endtask

    task automatic test_random_rx();
        logic [7:0] d, rd;
        logic       stop_bit, oe, rdy;
        for (int n = 0; n < 8; n++) begin
            d        = 8'($urandom);
            stop_bit = ($urandom_range(0, 3) != 0);
            send_rx(d, stop_bit);
            n_checks++; if (bus.uart_dataready !== exp_ready) $display("FAIL rrx_ready: byte %h stop %b got %b expected %b", d, stop_bit, bus.uart_dataready, exp_ready); else n_pass++;
            if ($urandom_range(0, 1) == 1) begin
                do_read(rd, oe, rdy);
                n_checks++; if (rd !== exp_rbr || oe !== 1'b1) $display("FAIL rrx_read: got %h/%b expected %h/1", rd, oe, exp_rbr); else n_pass++;
                n_checks++; if (rdy !== 1'b0) $display("FAIL rrx_ready_cleared: got %b expected 0", rdy); else n_pass++;
            end
        end
    endtask

    task automatic test_mid_reset();
        drive_write(8'($urandom));
        rxd = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        tick();
        exp_ready = 0;
        n_checks++; if (txd !== 1'b1) $display("FAIL mrst_txd: got %b expected 1", txd); else n_pass++;
        n_checks++; if (bus.uart_tsre !== 1'b1) $display("FAIL mrst_tsre: got %b expected 1", bus.uart_tsre); else n_pass++;
        n_checks++; if (bus.uart_tbre !== 1'b1) $display("FAIL mrst_tbre: got %b expected 1", bus.uart_tbre); else n_pass++;
        rst_n = 1'b1;
        rxd   = 1'b1;
        repeat (60) tick();
        n_checks++; if (bus.uart_dataready !== exp_ready) $display("FAIL mrst_rx_dropped: got %b expected %b", bus.uart_dataready, exp_ready); else n_pass++;
        n_checks++; if (txd !== 1'b1 || bus.uart_tsre !== 1'b1) $display("FAIL mrst_tx_idle: got %b/%b expected 1/1", txd, bus.uart_tsre); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_random_tx();
        test_receive();
        test_errors();
        test_overrun();
        test_random_rx();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/cpld_uart_responder.md
Name: cpld_uart_responder

Overview:
- Device side of the parallel UART strobe interface that the memory/IO controller drives: uart_rdn/uart_wrn strobes, an 8-bit data bus, and uart_dataready/uart_tbre/uart_tsre status.
- Converts strobed byte writes into 8N1 serial frames on txd, and deserializes rxd into a holding register read back via uart_rdn.
- Sits between the CPU-side controller and the board serial pins, replacing the external UART CPLD.

Parameters:
CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range 4..65535
SYNC_STAGES, 2, flip-flop stages on uart_rdn, uart_wrn and rxd; legal range 2..3

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
uart_rdn  input  1  read strobe, active low
uart_wrn  input  1  write strobe, active low
uart_data_i  input  8  write data from the initiator
uart_data_o  output  8  read data to the initiator
uart_data_oe  output  1  1 = responder drives the data bus
uart_dataready  output  1  1 = received byte waiting in the holding register
uart_tbre  output  1  1 = transmit holding register empty
uart_tsre  output  1  1 = transmit shifter empty and txd idle
txd  output  1  serial out, idle high
rxd  input  1  serial in, asynchronous

Behaviour:
- Reset: one clk edge with rst_n=0. Afterwards txd=1, uart_tbre=1, uart_tsre=1, uart_dataready=0, uart_data_oe=0, uart_data_o=0x00. Both state machines go to IDLE and the synchronizers are filled with 1.
- Reset mid-frame aborts the frame immediately: txd=1 on the next cycle, and any partial RX byte is dropped.
- Strobes are synchronized through SYNC_STAGES flops, then edge-detected with one extra register.
- Write: on the detected wrn falling edge, when uart_tbre=1, uart_data_i is captured into thr and uart_tbre drops to 0 on the next cycle. The initiator holds data stable for at least SYNC_STAGES+2 cycles after wrn falls.
- Write with uart_tbre=0 is ignored: thr is unchanged and no status changes.
- TX FSM states: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE. Each state lasts CLKS_PER_BIT cycles, counted by a bit counter and a baud counter.
- In IDLE with thr full, thr moves to the shifter. On that cycle uart_tbre returns to 1 and uart_tsre goes to 0. The start bit appears on txd on the following cycle.
- At the end of STOP, if thr is full it loads directly into START with no idle gap and uart_tsre stays 0. Otherwise the FSM returns to IDLE and uart_tsre rises to 1 on the same cycle.
- Read: while the synchronized rdn is low, uart_data_oe=1 and uart_data_o=rbr. uart_data_o returns to 0x00 when not reading.
- On the detected rdn rising edge, uart_dataready clears.
- RX FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE waits for the synchronized rxd=0.
  - START re-checks at CLKS_PER_BIT/2 (integer divide). If rxd is high the start is treated as a glitch and the FSM returns to IDLE.
  - Each DATA bit is sampled mid-bit every CLKS_PER_BIT cycles.
  - STOP is sampled mid-bit. Stop=1 writes rbr and sets uart_dataready the next cycle. Stop=0 is a framing error: the byte is discarded and the FSM waits for rxd=1 before re-entering IDLE.
- Overrun: a new byte arriving while uart_dataready=1 overwrites rbr and uart_dataready stays 1.
- Simultaneous rbr update and rdn rising edge: the update wins, so uart_dataready=1.
- Simultaneous rdn and wrn activity is legal and handled independently.
- Counter widths are $clog2(CLKS_PER_BIT). Counters wrap to 0 at CLKS_PER_BIT-1.

Optional Feature:
UART_EVEN_PARITY_EN
- Defined: the frame becomes 8E1. TX inserts a PARITY state after DATA carrying the XOR of the 8 data bits.
- Defined: RX samples parity and discards the byte on mismatch, exactly as for a framing error.
- Undefined: 8N1 only. No PARITY state or logic is generated.

Decomposition:
- Package uart_pkg:
  - TX/RX state enum typedef
  - FRAME_DATA_BITS=8
  - IDLE_LEVEL=1'b1
  - reset constants for the status outputs
- Sub-module uart_rx_deser: rxd synchronizer, RX FSM and mid-bit sampler. Outputs a byte plus a 1-cycle valid pulse.
- TX path, thr and the strobe decoding stay in the top module.

Test Plan:
- Reset/idle: CLKS_PER_BIT=4, release rst_n -> txd=1, uart_tbre=1, uart_tsre=1, uart_dataready=0, uart_data_oe=0.
- Single write: pulse uart_wrn low with data 0xA5 -> txd shows 0, then bits 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles wide. uart_tbre goes 0 then 1, and uart_tsre=0 for exactly 40 cycles.
- Back-to-back writes: write 0x55, then 0x0F as soon as uart_tbre=1 -> two frames with no idle gap. A third write while uart_tbre=0 is ignored.
- Receive: drive an 8N1 frame of 0x3C on rxd -> uart_dataready=1 after the stop sample. A uart_rdn pulse gives uart_data_o=0x3C with uart_data_oe=1, and uart_dataready=0 after rdn rises.
- Errors: a 1-cycle rxd low glitch -> no byte. A frame of 0x81 with stop=0 -> uart_dataready stays 0.
- Overrun and mid-frame reset: two frames 0x11 then 0x22 without a read -> a read returns 0x22. rst_n=0 mid-TX-frame -> txd=1 on the next cycle and uart_tsre=1.
